// File: rtl/dac_seq_pkg.sv
// dac_seq_pkg: shared state encoding, channel ids and counter width for the DAC write sequencer
package dac_seq_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, WRITE, HOLD} state_t;
  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;
  localparam int CNT_W = 8;
endpackage

// File: rtl/dac_write_sequencer_if.sv
// dac_write_sequencer_if: two waveform-source sample channels with valid/ready handshakes
interface dac_write_sequencer_if;
  logic a_req, b_req, a_ack, b_ack;
  logic [7:0] a_data, b_data;
  modport master(output a_req, a_data, b_req, b_data, input a_ack, b_ack);
  modport slave(input a_req, a_data, b_req, b_data, output a_ack, b_ack);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, the channel that was not granted last wins contention
module rr_arb2 import dac_seq_pkg::*; (
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);
  assign grant[CH_A] = en && req[CH_A] && (!req[CH_B] || last_grant == CH_B);
  assign grant[CH_B] = en && req[CH_B] && (!req[CH_A] || last_grant == CH_A);
endmodule

// File: rtl/dac_write_sequencer.sv
// dac_write_sequencer: arbitrates two sample sources onto one parallel DAC and
// generates registered CSn/WRn/DACsel timing (setup, write pulse, hold, idle).
module dac_write_sequencer import dac_seq_pkg::*; #(
  parameter int SETUP_CYC = 1,
  parameter int WR_CYC    = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  en,
  dac_write_sequencer_if.slave  src,
  output logic [7:0]            DACdata,
  output logic                  CSn,
  output logic                  WRn,
  output logic                  DACsel,
  output logic                  busy
);
  if (SETUP_CYC < 1 || SETUP_CYC > 255 || WR_CYC < 1 || WR_CYC > 255 ||
      HOLD_CYC < 1 || HOLD_CYC > 255) begin : g_bad_param
    $error("dac_write_sequencer: SETUP_CYC, WR_CYC and HOLD_CYC must be 1..255");
  end
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             last_grant;
  logic [1:0]       gnt;
  // rstn gates the grant so an ack can never be shown while the sequencer is held in reset
  rr_arb2 u_arb (
    .req        ({src.b_req, src.a_req}),
    .last_grant (last_grant),
    .en         (en && rstn && state == IDLE),
    .grant      (gnt)
  );
  assign src.a_ack = gnt[CH_A];
  assign src.b_ack = gnt[CH_B];
  assign busy      = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n   = cnt - CNT_W'(1);
    case (state)
      IDLE: begin
        state_n = |gnt ? SETUP : IDLE;
        cnt_n   = |gnt ? SETUP_LD : cnt;
      end
      SETUP: if (cnt == '0) begin
        state_n = WRITE;
        cnt_n   = WR_LD;
      end
      WRITE: if (cnt == '0) begin
        state_n = HOLD;
        cnt_n   = HOLD_LD;
      end
      default: if (cnt == '0) begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end
  // strobes are decoded from the next state so the pins change on the transition edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      cnt        <= '0;
      CSn        <= 1'b1;
      WRn        <= 1'b1;
      DACsel     <= CH_A;
      DACdata    <= '0;
      last_grant <= CH_B;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      CSn   <= state_n == IDLE;
      WRn   <= state_n != WRITE;
      if (|gnt) begin
        DACsel     <= gnt[CH_B];
        DACdata    <= gnt[CH_B] ? src.b_data : src.a_data;
        last_grant <= gnt[CH_B];
      end
    end
  end
endmodule

// File: tb/tb_dac_write_sequencer.sv
// tb_dac_write_sequencer: default and stretched-timing sequencers driven with identical stimulus,
// checked by a transfer-age reference model, a vector table and hand-written corner sequences.
module tb_dac_write_sequencer;
  logic clk = 0, rstn = 0, en = 0, a_req = 0, b_req = 0;
  logic [7:0] a_data = 0, b_data = 0;
  logic mon_on = 0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  dac_write_sequencer_if if0(), if1();
  assign if0.a_req = a_req;
  assign if0.b_req = b_req;
  assign if0.a_data = a_data;
  assign if0.b_data = b_data;
  assign if1.a_req = a_req;
  assign if1.b_req = b_req;
  assign if1.a_data = a_data;
  assign if1.b_data = b_data;

  logic [7:0] dd [2];
  logic cs [2], wr [2], sl [2], bz [2], aa [2], ba [2];
  assign aa[0] = if0.a_ack;
  assign ba[0] = if0.b_ack;
  assign aa[1] = if1.a_ack;
  assign ba[1] = if1.b_ack;

  dac_write_sequencer u0 (
    .clk(clk), .rstn(rstn), .en(en), .src(if0.slave),
    .DACdata(dd[0]), .CSn(cs[0]), .WRn(wr[0]), .DACsel(sl[0]), .busy(bz[0])
  );
  dac_write_sequencer #(.SETUP_CYC(3), .WR_CYC(4), .HOLD_CYC(2)) u1 (
    .clk(clk), .rstn(rstn), .en(en), .src(if1.slave),
    .DACdata(dd[1]), .CSn(cs[1]), .WRn(wr[1]), .DACsel(sl[1]), .busy(bz[1])
  );

  function automatic int sp(int d); return d ? 3 : 1; endfunction
  function automatic int wp(int d); return d ? 4 : 2; endfunction
  function automatic int hp(int d); return d ? 2 : 1; endfunction
  function automatic int tot(int d); return sp(d) + wp(d) + hp(d); endfunction

  task automatic cmp(string nm, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, d, $time, act, exp);
    end
  endtask

  // Reference model: age of the current transfer in cycles since its grant edge.
  // Age tot(d) and beyond means idle; strobe windows follow from the parameter sums.
  int mn [2];
  logic [7:0] md [2];
  logic ms [2], ml [2];
  logic m_idle, m_ga, m_gb;
  initial for (int d = 0; d < 2; d++) begin
    mn[d] = tot(d); md[d] = 0; ms[d] = 0; ml[d] = 1;
  end
  always @(negedge clk) if (mon_on) for (int d = 0; d < 2; d++) begin
    m_idle = mn[d] >= tot(d);
    m_ga = rstn && en && m_idle && a_req && (!b_req || ml[d]);
    m_gb = rstn && en && m_idle && b_req && (!a_req || !ml[d]);
    cmp("a_ack", d, aa[d], m_ga);
    cmp("b_ack", d, ba[d], m_gb);
    cmp("one_ack", d, aa[d] & ba[d], 0);
    cmp("CSn", d, cs[d], m_idle);
    cmp("WRn", d, wr[d], !(mn[d] >= sp(d) && mn[d] < sp(d) + wp(d)));
    cmp("busy", d, bz[d], !m_idle);
    cmp("DACsel", d, sl[d], ms[d]);
    cmp("DACdata", d, dd[d], md[d]);
    if (!rstn) begin
      mn[d] = tot(d); md[d] = 0; ms[d] = 0; ml[d] = 1;
    end else if (m_ga || m_gb) begin
      mn[d] = 0; md[d] = m_gb ? b_data : a_data; ms[d] = m_gb; ml[d] = m_gb;
    end else if (mn[d] < tot(d)) mn[d]++;
  end

  typedef struct {
    logic ar; logic [7:0] ad; logic br; logic [7:0] bd;
    logic xa, xb, xcs, xwr, xsel; logic [7:0] xd;
  } vec_t;
  vec_t tv [22];
  function automatic vec_t mkv(logic ar, logic [7:0] ad, logic br, logic [7:0] bd,
                               logic xa, logic xb, logic xcs, logic xwr, logic xsel, logic [7:0] xd);
    vec_t v;
    v.ar = ar; v.ad = ad; v.br = br; v.bd = bd;
    v.xa = xa; v.xb = xb; v.xcs = xcs; v.xwr = xwr; v.xsel = xsel; v.xd = xd;
    return v;
  endfunction

  task automatic wait_ack(int d);
    int k = 0;
    while (!(aa[d] || ba[d]) && k < 60) begin @(negedge clk); k++; end
    cmp("ack_wait_in_time", d, k < 60, 1);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((bz[0] || bz[1]) && k < 60) begin @(negedge clk); k++; end
    cmp("idle_wait_in_time", 0, k < 60, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cs_lo, wr_lo, first_wr, acks;
    logic g;
    tv[0]  = mkv(1, 8'h5A, 0, 8'h00, 1, 0, 1, 1, 0, 8'h00);
    tv[1]  = mkv(1, 8'h5A, 0, 8'h00, 0, 0, 0, 1, 0, 8'h5A);
    tv[2]  = mkv(1, 8'h5A, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A);
    tv[3]  = mkv(1, 8'h5A, 0, 8'h00, 0, 0, 0, 0, 0, 8'h5A);
    tv[4]  = mkv(1, 8'h5A, 0, 8'h00, 0, 0, 0, 1, 0, 8'h5A);
    tv[5]  = mkv(1, 8'h5A, 0, 8'h00, 1, 0, 1, 1, 0, 8'h5A);
    tv[6]  = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 0, 8'h5A);
    tv[7]  = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 0, 0, 8'h5A);
    tv[8]  = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 0, 0, 8'h5A);
    tv[9]  = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 0, 8'h5A);
    tv[10] = mkv(1, 8'h11, 1, 8'h22, 0, 1, 1, 1, 0, 8'h5A);
    tv[11] = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 1, 8'h22);
    tv[12] = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 0, 1, 8'h22);
    tv[13] = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 0, 1, 8'h22);
    tv[14] = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 1, 8'h22);
    tv[15] = mkv(1, 8'h11, 1, 8'h22, 1, 0, 1, 1, 1, 8'h22);
    tv[16] = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 0, 8'h11);
    tv[17] = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 0, 0, 8'h11);
    tv[18] = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 0, 0, 8'h11);
    tv[19] = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 0, 8'h11);
    tv[20] = mkv(1, 8'h11, 1, 8'h22, 0, 1, 1, 1, 0, 8'h11);
    tv[21] = mkv(1, 8'h11, 1, 8'h22, 0, 0, 0, 1, 1, 8'h22);

    repeat (2) @(posedge clk);
    mon_on = 1;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
      rstn = 1; en = 1;
      a_req = tv[i].ar; a_data = tv[i].ad; b_req = tv[i].br; b_data = tv[i].bd;
      @(negedge clk);
      cmp($sformatf("vec%0d_a_ack", i), 0, aa[0], tv[i].xa);
      cmp($sformatf("vec%0d_b_ack", i), 0, ba[0], tv[i].xb);
      cmp($sformatf("vec%0d_CSn", i), 0, cs[0], tv[i].xcs);
      cmp($sformatf("vec%0d_WRn", i), 0, wr[0], tv[i].xwr);
      cmp($sformatf("vec%0d_DACsel", i), 0, sl[0], tv[i].xsel);
      cmp($sformatf("vec%0d_DACdata", i), 0, dd[0], tv[i].xd);
    end

    // stretched timing, single B request
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    wait_idle();
    @(posedge clk); #1;
    b_req = 1; b_data = 8'h3C;
    @(negedge clk);
    wait_ack(1);
    cs_lo = 0; wr_lo = 0; first_wr = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (!cs[1]) cs_lo++;
      if (!wr[1]) begin wr_lo++; if (first_wr == 0) first_wr = i; end
      if (i == 1) begin cmp("long_sel_b", 1, sl[1], 1); cmp("long_data", 1, dd[1], 8'h3C); end
      if (i == 10) cmp("long_period_ack", 1, ba[1], 1);
    end
    cmp("long_cs_low_len", 1, cs_lo, 9);
    cmp("long_wr_low_len", 1, wr_lo, 4);
    cmp("long_wr_offset", 1, first_wr, 4);

    // en dropped in WRITE
    @(posedge clk); #1;
    a_req = 1; a_data = 8'h11; b_req = 1; b_data = 8'h22;
    @(negedge clk);
    wait_ack(0);
    g = ba[0];
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 0;
    cs_lo = 0; wr_lo = 0; acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!cs[0]) cs_lo++;
      if (!wr[0]) wr_lo++;
      if (aa[0] || ba[0] || aa[1] || ba[1]) acks++;
    end
    cmp("en_low_wr_rest", 0, wr_lo, 2);
    cmp("en_low_cs_rest", 0, cs_lo, 3);
    cmp("en_low_no_acks", 0, acks, 0);
    @(posedge clk); #1;
    en = 1;
    @(negedge clk);
    cmp("resume_a_ack", 0, aa[0], g);
    cmp("resume_b_ack", 0, ba[0], !g);

    // reset in second WRITE cycle
    wait_ack(0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn = 0;
    @(negedge clk);
    cmp("in_write2_WRn", 0, wr[0], 0);
    @(posedge clk); #1;
    @(negedge clk);
    cmp("rst_CSn", 0, cs[0], 1);
    cmp("rst_WRn", 0, wr[0], 1);
    cmp("rst_DACdata", 0, dd[0], 0);
    cmp("rst_DACsel", 0, sl[0], 0);
    cmp("rst_busy", 0, bz[0], 0);
    cmp("rst_no_ack", 0, aa[0] | ba[0], 0);
    @(posedge clk); #1;
    rstn = 1;
    @(negedge clk);
    cmp("post_rst_a_first", 0, aa[0], 1);
    cmp("post_rst_b_wait", 0, ba[0], 0);

    // no requests for 20 cycles
    @(posedge clk); #1;
    a_req = 0; b_req = 0;
    wait_idle();
    repeat (20) @(negedge clk);
    cmp("quiet_CSn", 0, cs[0], 1);
    cmp("quiet_WRn", 0, wr[0], 1);
    cmp("quiet_busy", 0, bz[0], 0);
    cmp("quiet_DACdata", 0, dd[0], 8'h11);

    // randomized traffic, checked by the model
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      rstn = $urandom_range(0, 49) != 0;
      en = $urandom_range(0, 7) != 0;
      a_req = $urandom_range(0, 2) != 0;
      b_req = $urandom_range(0, 2) != 0;
      a_data = 8'($urandom);
      b_data = 8'($urandom);
    end
    @(negedge clk);
    mon_on = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
